// File: rtl/gray_sync_decoder.sv
// Destination side of a Gray-coded counter crossing: synchronizes gray_in,
// decodes it to binary and classifies each change as up, down or illegal.
module gray_sync_decoder #(
    parameter int WIDTH       = 4,
    parameter int SYNC_STAGES = 2,
    parameter int ERR_CNT_W   = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [WIDTH-1:0]     gray_in,
    input  logic                 clr_err,
    output logic [WIDTH-1:0]     bin_out,
    output logic                 bin_valid,
    output logic                 up_pulse,
    output logic                 down_pulse,
    output logic                 err_pulse,
    output logic [ERR_CNT_W-1:0] err_cnt
);

    localparam logic [0:0]           ST_INIT  = 1'b0;
    localparam logic [0:0]           ST_TRACK = 1'b1;
    localparam logic [WIDTH-1:0]     DELTA_UP = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0]     DELTA_DN = {WIDTH{1'b1}};
    localparam logic [ERR_CNT_W-1:0] CNT_MAX  = {ERR_CNT_W{1'b1}};
    localparam logic [ERR_CNT_W-1:0] CNT_ONE  = {{(ERR_CNT_W-1){1'b0}}, 1'b1};
    localparam logic [ERR_CNT_W-1:0] CNT_ZERO = {ERR_CNT_W{1'b0}};

    function automatic logic [WIDTH-1:0] gray2bin(input logic [WIDTH-1:0] g);
        logic [WIDTH-1:0] b;
        b[WIDTH-1] = g[WIDTH-1];
        for (int i = WIDTH-2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    logic [WIDTH-1:0]     sync_r [SYNC_STAGES];
    logic [WIDTH-1:0]     gray_prev_r;
    logic [WIDTH-1:0]     bin_r;
    logic                 valid_r;
    logic                 up_r;
    logic                 down_r;
    logic                 err_r;
    logic [ERR_CNT_W-1:0] cnt_r;
    logic [0:0]           state_r;

    logic [WIDTH-1:0]     g_s;
    logic [WIDTH-1:0]     b_s;
    logic [WIDTH-1:0]     delta_s;
    logic                 changed_s;
    logic                 up_s;
    logic                 down_s;
    logic                 err_s;

    // Plain flop chain on the asynchronous input; nothing may sit between stages.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_r[i] <= {WIDTH{1'b0}};
            end
        end else begin
            sync_r[0] <= gray_in;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_r[i] <= sync_r[i-1];
            end
        end
    end

    assign g_s       = sync_r[SYNC_STAGES-1];
    assign b_s       = gray2bin(g_s);
    assign delta_s   = b_s - bin_r;
    assign changed_s = (g_s != gray_prev_r);

    // Classify a change; only meaningful once the first value has been loaded.
    always_comb begin
        up_s   = 1'b0;
        down_s = 1'b0;
        err_s  = 1'b0;
        if ((state_r == ST_TRACK) && changed_s) begin
            if (delta_s == DELTA_UP) begin
                up_s = 1'b1;
            end else if (delta_s == DELTA_DN) begin
                down_s = 1'b1;
            end else begin
                err_s = 1'b1;
            end
        end else begin
            up_s   = 1'b0;
            down_s = 1'b0;
            err_s  = 1'b0;
        end
    end

    // INIT takes the first synchronized value silently, TRACK follows every change.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_INIT;
            gray_prev_r <= {WIDTH{1'b0}};
            bin_r       <= {WIDTH{1'b0}};
            valid_r     <= 1'b0;
            up_r        <= 1'b0;
            down_r      <= 1'b0;
            err_r       <= 1'b0;
        end else begin
            case (state_r)
                ST_INIT: begin
                    gray_prev_r <= g_s;
                    bin_r       <= b_s;
                    valid_r     <= 1'b1;
                    up_r        <= 1'b0;
                    down_r      <= 1'b0;
                    err_r       <= 1'b0;
                    state_r     <= ST_TRACK;
                end
                ST_TRACK: begin
                    up_r   <= up_s;
                    down_r <= down_s;
                    err_r  <= err_s;
                    if (changed_s) begin
                        gray_prev_r <= g_s;
                        bin_r       <= b_s;
                    end else begin
                        gray_prev_r <= gray_prev_r;
                        bin_r       <= bin_r;
                    end
                end
                default: begin
                    state_r <= ST_INIT;
                    valid_r <= 1'b0;
                    up_r    <= 1'b0;
                    down_r  <= 1'b0;
                    err_r   <= 1'b0;
                end
            endcase
        end
    end

    // Saturating error counter; a clear coinciding with a new error leaves one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r <= CNT_ZERO;
        end else if (clr_err) begin
            cnt_r <= err_s ? CNT_ONE : CNT_ZERO;
        end else if (err_s && (cnt_r != CNT_MAX)) begin
            cnt_r <= cnt_r + CNT_ONE;
        end else begin
            cnt_r <= cnt_r;
        end
    end

    assign bin_out    = bin_r;
    assign bin_valid  = valid_r;
    assign up_pulse   = up_r;
    assign down_pulse = down_r;
    assign err_pulse  = err_r;
    assign err_cnt    = cnt_r;

endmodule

// File: tb/tb_gray_sync_decoder.sv
// Directed bench for gray_sync_decoder: expected change events are queued as
// stimulus is driven and matched against pulses observed on the outputs.
module tb_gray_sync_decoder;

    localparam int W  = 4;
    localparam int S  = 2;
    localparam int CW = 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          clr_err = 1'b0;
    logic [W-1:0]  gray_in = 4'b0000;
    logic [W-1:0]  bin_out;
    logic          bin_valid;
    logic          up_pulse;
    logic          down_pulse;
    logic          err_pulse;
    logic [CW-1:0] err_cnt;

    typedef struct packed {
        logic [W-1:0]  bin;
        logic          up;
        logic          dn;
        logic          er;
        logic [CW-1:0] cnt;
    } ev_t;

    ev_t q[$];
    int  errors = 0;
    int  checks = 0;
    int  n_up = 0;
    int  n_dn = 0;
    int  n_er = 0;
    int  err_model = 0;

    gray_sync_decoder #(.WIDTH(W), .SYNC_STAGES(S), .ERR_CNT_W(CW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .gray_in    (gray_in),
        .clr_err    (clr_err),
        .bin_out    (bin_out),
        .bin_valid  (bin_valid),
        .up_pulse   (up_pulse),
        .down_pulse (down_pulse),
        .err_pulse  (err_pulse),
        .err_cnt    (err_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [W-1:0] b2g(input logic [W-1:0] b);
        return b ^ (b >> 1);
    endfunction

    // kind: 0 = up-step, 1 = down-step, 2 = illegal jump
    task automatic expect_ev(input logic [W-1:0] bin, input int kind);
        ev_t e;
        if (kind == 2 && err_model < 255) err_model++;
        e.bin = bin;
        e.up  = (kind == 0);
        e.dn  = (kind == 1);
        e.er  = (kind == 2);
        e.cnt = CW'(err_model);
        q.push_back(e);
    endtask

    task automatic apply(input logic [W-1:0] bin, input int kind, input string tag);
        expect_ev(bin, kind);
        gray_in = b2g(bin);
        repeat (4) @(negedge clk);
        check({tag, " event seen"}, 32'(q.size()), 32'd0);
        check({tag, " bin_out"}, 32'(bin_out), 32'(bin));
    endtask

    task automatic check_zero(input string tag);
        check(tag, 32'({bin_out, bin_valid, up_pulse, down_pulse, err_pulse, err_cnt}), 32'd0);
    endtask

    // Every pulse must match the oldest queued expectation.
    always @(negedge clk) begin : monitor
        ev_t e;
        if (up_pulse || down_pulse || err_pulse) begin
            n_up = n_up + int'(up_pulse);
            n_dn = n_dn + int'(down_pulse);
            n_er = n_er + int'(err_pulse);
            if (q.size() == 0) begin
                check("spurious pulse", 32'({up_pulse, down_pulse, err_pulse}), 32'd0);
            end else begin
                e = q.pop_front();
                check("event", 32'({bin_out, up_pulse, down_pulse, err_pulse, err_cnt}), 32'(e));
            end
        end
    end

    initial begin
        // 1: reset with 0110 held, flushed INIT load then a 0->4 jump
        gray_in = 4'b0110;
        rst_n   = 1'b0;
        repeat (3) @(negedge clk);
        check_zero("t1 reset outputs");
        expect_ev(4'd4, 2);
        rst_n = 1'b1;
        @(negedge clk);
        check("t1 valid edge1", 32'(bin_valid), 32'd1);
        check("t1 bin edge1", 32'(bin_out), 32'd0);
        @(negedge clk);
        check("t1 bin edge2", 32'(bin_out), 32'd0);
        @(negedge clk);
        check("t1 bin edge3", 32'(bin_out), 32'd4);
        @(negedge clk);
        check("t1 err event seen", 32'(q.size()), 32'd0);

        rst_n   = 1'b0;
        gray_in = 4'b0000;
        repeat (2) @(negedge clk);
        check_zero("t1b reset outputs");
        err_model = 0;
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        check("t1b bin", 32'(bin_out), 32'd0);
        check("t1b valid", 32'(bin_valid), 32'd1);
        check("t1b err_cnt", 32'(err_cnt), 32'd0);

        // 2: count up through the wrap
        n_up = 0; n_dn = 0; n_er = 0;
        for (int k = 1; k <= 16; k++) apply(W'(k % 16), 0, "t2 up");
        check("t2 up count", 32'(n_up), 32'd16);
        check("t2 down count", 32'(n_dn), 32'd0);
        check("t2 err count", 32'(n_er), 32'd0);
        check("t2 err_cnt", 32'(err_cnt), 32'd0);

        // 3: up to 3, then down through the wrap to 15
        for (int k = 1; k <= 3; k++) apply(W'(k), 0, "t3 setup");
        n_up = 0; n_dn = 0; n_er = 0;
        apply(4'd2, 1, "t3 down2");
        apply(4'd1, 1, "t3 down1");
        apply(4'd0, 1, "t3 down0");
        apply(4'd15, 1, "t3 down15");
        check("t3 down count", 32'(n_dn), 32'd4);
        check("t3 up count", 32'(n_up), 32'd0);
        check("t3 err count", 32'(n_er), 32'd0);

        // 4: illegal jump 0 -> 7, then 7 -> 6
        apply(4'd0, 0, "t4 wrap");
        n_er = 0;
        apply(4'd7, 2, "t4 jump");
        check("t4 err_cnt", 32'(err_cnt), 32'd1);
        check("t4 err count", 32'(n_er), 32'd1);
        apply(4'd6, 1, "t4 down");

        // 5: saturate, clear with coincident error, plain clear
        for (int i = 0; i < 300; i++) apply((i % 2 == 0) ? 4'd0 : 4'd4, 2, "t5 toggle");
        check("t5 saturated", 32'(err_cnt), 32'd255);
        err_model = 0;
        expect_ev(4'd0, 2);
        gray_in = 4'b0000;
        repeat (2) @(negedge clk);
        clr_err = 1'b1;
        @(negedge clk);
        clr_err = 1'b0;
        @(negedge clk);
        check("t5 clr+err event seen", 32'(q.size()), 32'd0);
        check("t5 clr+err cnt", 32'(err_cnt), 32'd1);
        clr_err = 1'b1;
        @(negedge clk);
        clr_err = 1'b0;
        err_model = 0;
        check("t5 clr cnt", 32'(err_cnt), 32'd0);
        check("t5 clr bin", 32'(bin_out), 32'd0);
        check("t5 clr valid", 32'(bin_valid), 32'd1);

        // 6: reset mid-operation at bin 13
        apply(4'd13, 2, "t6 to13");
        rst_n = 1'b0;
        #1;
        check_zero("t6 async reset");
        err_model = 0;
        @(negedge clk);
        rst_n = 1'b1;
        expect_ev(4'd13, 2);
        @(negedge clk);
        check("t6 init valid", 32'(bin_valid), 32'd1);
        check("t6 init bin", 32'(bin_out), 32'd0);
        repeat (2) @(negedge clk);
        check("t6 bin edge3", 32'(bin_out), 32'd13);
        repeat (3) @(negedge clk);
        check("t6 event seen", 32'(q.size()), 32'd0);
        check("t6 bin stable", 32'(bin_out), 32'd13);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
